// File: rtl/ifetch_ctrl_pkg.sv
// ============================================================================
// ifetch_ctrl_pkg : shared widths, reset address and queue-entry layout
// Revision: 1.0
// ============================================================================
`default_nettype none

package ifetch_ctrl_pkg;

   localparam int         IMEM_ADDR_W      = 8;
   localparam int         INSTR_W          = 8;
   localparam logic [7:0] RESET_PC_DEFAULT = 8'h00;

   // Packed as {pc[15:8], data[7:0]}
   typedef struct packed {
      logic [IMEM_ADDR_W-1:0] pc;
      logic [INSTR_W-1:0]     data;
   } qentry_t;

endpackage

`default_nettype wire

// File: rtl/ifetch_ctrl_queue.sv
// ============================================================================
// ifetch_queue : DEPTH-entry flushable FIFO holding fetched {pc, data} pairs
// Revision: 1.0
// ============================================================================
`default_nettype none

module ifetch_queue
   import ifetch_ctrl_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         push_i,
   input  qentry_t                      entry_i,
   input  logic                         pop_i,
   input  logic                         flush_i,
   output logic [$clog2(DEPTH+1)-1:0]   count_o,
   output logic                         valid_o,
   output qentry_t                      head_o
);

   localparam int CW = $clog2(DEPTH+1);
   localparam int PW = $clog2(DEPTH);

   logic [PW-1:0] rd_q, wr_q;
   logic [CW-1:0] cnt_q;
   qentry_t       mem_q [DEPTH];

   function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH-1)) ? '0 : p + 1'b1;
   endfunction

   // Flush drops everything, including a same-cycle push; a same-cycle pop
   // has already taken the head that is visible this cycle.
   always_ff @(posedge clk) begin
      if (reset || flush_i) begin
         rd_q  <= '0;
         wr_q  <= '0;
         cnt_q <= '0;
      end else begin
         if (push_i) wr_q <= inc(wr_q);
         if (pop_i)  rd_q <= inc(rd_q);
         case ({push_i, pop_i})
            2'b10:   cnt_q <= cnt_q + 1'b1;
            2'b01:   cnt_q <= cnt_q - 1'b1;
            default: cnt_q <= cnt_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push_i && !flush_i) mem_q[wr_q] <= entry_i;
   end

   assign count_o = cnt_q;
   assign valid_o = (cnt_q != '0);
   assign head_o  = valid_o ? mem_q[rd_q] : '0;

endmodule

`default_nettype wire

// File: rtl/ifetch_ctrl.sv
// ============================================================================
// ifetch_ctrl : PC, single in-flight read tracking, credit check, address mux
// Revision: 1.0
// ============================================================================
`default_nettype none

module ifetch_ctrl
   import ifetch_ctrl_pkg::*;
#(
   parameter logic [IMEM_ADDR_W-1:0] RESET_PC = RESET_PC_DEFAULT,
   parameter int                     DEPTH    = 2
) (
   input  logic                   clk,
   input  logic                   reset,
   output logic [IMEM_ADDR_W-1:0] imem_addr,
   input  logic [INSTR_W-1:0]     imem_data,
   output logic                   inst_valid,
   input  logic                   inst_ready,
   output logic [INSTR_W-1:0]     inst_data,
   output logic [IMEM_ADDR_W-1:0] inst_pc,
   input  logic                   redirect_valid,
   input  logic [IMEM_ADDR_W-1:0] redirect_pc,
   input  logic                   halt,
   output logic                   busy
);

   localparam int CW  = $clog2(DEPTH+1);
   localparam int CW1 = CW + 1;

   logic [IMEM_ADDR_W-1:0] pc_q, pc_d;
   logic [IMEM_ADDR_W-1:0] infl_pc_q, infl_pc_d;
   logic                   infl_q, infl_d;
   logic [CW-1:0]          count;
   logic [CW1-1:0]         credit;
   logic                   pop, issue, head_valid;
   qentry_t                head;

   ifetch_queue #(.DEPTH(DEPTH)) u_queue (
      .clk     (clk),
      .reset   (reset),
      .push_i  (infl_q),
      .entry_i ('{pc: infl_pc_q, data: imem_data}),
      .pop_i   (pop),
      .flush_i (redirect_valid),
      .count_o (count),
      .valid_o (head_valid),
      .head_o  (head)
   );

   assign pop = head_valid & inst_ready;

   // Occupancy the queue will have once the in-flight byte lands; a new read
   // is only issued if its byte is guaranteed a free slot.
   assign credit = {1'b0, count} + CW1'(infl_q) - CW1'(pop);
   assign issue  = !halt && !redirect_valid && (credit < CW1'(DEPTH));

   assign imem_addr = redirect_valid ? redirect_pc : pc_q;

   always_comb begin
      pc_d      = pc_q;
      infl_d    = 1'b0;
      infl_pc_d = infl_pc_q;
      if (redirect_valid) begin
         if (!halt) begin
            infl_d    = 1'b1;
            infl_pc_d = redirect_pc;
            pc_d      = redirect_pc + 8'd1;
         end else begin
            pc_d      = redirect_pc;
         end
      end else if (issue) begin
         infl_d    = 1'b1;
         infl_pc_d = pc_q;
         pc_d      = pc_q + 8'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pc_q      <= RESET_PC;
         infl_q    <= 1'b0;
         infl_pc_q <= '0;
      end else begin
         pc_q      <= pc_d;
         infl_q    <= infl_d;
         infl_pc_q <= infl_pc_d;
      end
   end

   assign inst_valid = head_valid;
   assign inst_data  = head.data;
   assign inst_pc    = head.pc;
   assign busy       = infl_q | head_valid;

endmodule

`default_nettype wire

// File: tb/tb_ifetch_ctrl.sv
// ============================================================================
// tb_ifetch_ctrl : vector table, corner-case sequences and random stream check
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_ifetch_ctrl;

   logic       clk = 1'b0;
   logic       reset, inst_ready, redirect_valid, halt;
   logic [7:0] redirect_pc;
   logic [7:0] imem_addr, imem_data, inst_data, inst_pc;
   logic       inst_valid, busy;
   logic [7:0] imem_addr2, imem_data2, inst_data2, inst_pc2;
   logic       inst_valid2, busy2;
   logic [7:0] mem [256];

   int n_cmp  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   // Synchronous-read memories; reset zeros their outputs
   always @(posedge clk) begin
      if (reset) begin
         imem_data  <= 8'h00;
         imem_data2 <= 8'h00;
      end else begin
         imem_data  <= mem[imem_addr];
         imem_data2 <= mem[imem_addr2];
      end
   end

   ifetch_ctrl dut (
      .clk(clk), .reset(reset), .imem_addr(imem_addr), .imem_data(imem_data),
      .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_data(inst_data),
      .inst_pc(inst_pc), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .halt(halt), .busy(busy)
   );

   ifetch_ctrl #(.RESET_PC(8'hFE)) dut_wrap (
      .clk(clk), .reset(reset), .imem_addr(imem_addr2), .imem_data(imem_data2),
      .inst_valid(inst_valid2), .inst_ready(1'b1), .inst_data(inst_data2),
      .inst_pc(inst_pc2), .redirect_valid(1'b0), .redirect_pc(8'h00),
      .halt(1'b0), .busy(busy2)
   );

   typedef struct {
      logic       rst, rdy, chk, hd, ev;
      logic [7:0] epc, edat, eaddr;
      logic       ebusy;
   } vec_t;

   vec_t vt[$];

   function automatic vec_t mk(input logic rst, rdy, chk, hd, ev,
                               input logic [7:0] epc, edat, eaddr,
                               input logic ebusy);
      vec_t r;
      r.rst = rst; r.rdy = rdy; r.chk = chk; r.hd = hd; r.ev = ev;
      r.epc = epc; r.edat = edat; r.eaddr = eaddr; r.ebusy = ebusy;
      return r;
   endfunction

   task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual %02h required %02h", nm, act, exp);
      end
   endtask

   task automatic drive(input logic r, input logic rdy, input logic rv,
                        input logic [7:0] rpc, input logic h);
      @(posedge clk);
      #1;
      reset = r; inst_ready = rdy; redirect_valid = rv; redirect_pc = rpc; halt = h;
      @(negedge clk);
   endtask

   task automatic chk_head(input string nm, input logic [7:0] pc);
      check({nm, ".valid"}, 8'(inst_valid), 8'h01);
      check({nm, ".pc"},    inst_pc, pc);
      check({nm, ".data"},  inst_data, mem[pc]);
   endtask

   initial begin
      logic [7:0] exp_pc, rpc, prev_pc, prev_dat, e;
      logic       rv, rdy, h, prev_hold;
      int         pops;

      for (int i = 0; i < 256; i++) mem[i] = 8'hA0 + 8'(i);
      reset = 1'b1; inst_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = 8'h00; halt = 1'b0;

      // Stall with ready low for 5 cycles, then resume
      vt.push_back(mk(1,0,0,0,0, 8'h00, 8'h00, 8'h00, 0));
      vt.push_back(mk(1,0,0,0,0, 8'h00, 8'h00, 8'h00, 0));
      vt.push_back(mk(0,0,1,1,0, 8'h00, 8'h00, 8'h00, 0));
      vt.push_back(mk(0,0,1,0,0, 8'h00, 8'h00, 8'h01, 1));
      for (int k = 0; k < 5; k++) vt.push_back(mk(0,0,1,0,1, 8'h00, 8'hA0, 8'h02, 1));
      vt.push_back(mk(0,1,1,0,1, 8'h00, 8'hA0, 8'h02, 1));
      for (int k = 1; k < 4; k++) vt.push_back(mk(0,1,1,0,1, 8'(k), 8'hA0 + 8'(k), 8'(k+2), 1));
      // Fresh reset, free-running stream
      vt.push_back(mk(1,1,0,0,0, 8'h00, 8'h00, 8'h00, 0));
      vt.push_back(mk(1,1,0,0,0, 8'h00, 8'h00, 8'h00, 0));
      vt.push_back(mk(0,1,1,1,0, 8'h00, 8'h00, 8'h00, 0));
      vt.push_back(mk(0,1,1,0,0, 8'h00, 8'h00, 8'h01, 1));
      for (int k = 0; k < 4; k++) vt.push_back(mk(0,1,1,0,1, 8'(k), 8'hA0 + 8'(k), 8'(k+2), 1));

      foreach (vt[i]) begin
         drive(vt[i].rst, vt[i].rdy, 1'b0, 8'h00, 1'b0);
         if (vt[i].chk) begin
            check($sformatf("v%0d.valid", i), 8'(inst_valid), 8'(vt[i].ev));
            check($sformatf("v%0d.addr", i), imem_addr, vt[i].eaddr);
            check($sformatf("v%0d.busy", i), 8'(busy), 8'(vt[i].ebusy));
            if (vt[i].ev || vt[i].hd) begin
               check($sformatf("v%0d.pc", i), inst_pc, vt[i].epc);
               check($sformatf("v%0d.data", i), inst_data, vt[i].edat);
            end
         end
      end

      // Redirect mid-stream: head pop completes, old stream never reappears
      drive(1'b0, 1'b1, 1'b1, 8'h40, 1'b0);
      chk_head("redir.pop", 8'h04);
      check("redir.addr", imem_addr, 8'h40);
      drive(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
      check("redir.gap", 8'(inst_valid), 8'h00);
      drive(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
      chk_head("redir.first", 8'h40);
      drive(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
      chk_head("redir.second", 8'h41);

      // Halt with a read in flight: it drains, then nothing more
      drive(1'b0, 1'b1, 1'b0, 8'h00, 1'b1);
      chk_head("halt.h0", 8'h42);
      drive(1'b0, 1'b1, 1'b0, 8'h00, 1'b1);
      chk_head("halt.inflight", 8'h43);
      for (int k = 0; k < 3; k++) begin
         drive(1'b0, 1'b1, 1'b0, 8'h00, 1'b1);
         check("halt.valid", 8'(inst_valid), 8'h00);
         check("halt.busy", 8'(busy), 8'h00);
         check("halt.addr", imem_addr, 8'h44);
      end
      drive(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
      drive(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
      check("resume.gap", 8'(inst_valid), 8'h00);
      drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
      chk_head("resume.first", 8'h44);

      // Reset with two entries queued
      drive(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
      chk_head("prereset.head", 8'h44);
      drive(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
      check("rst.valid", 8'(inst_valid), 8'h00);
      check("rst.busy", 8'(busy), 8'h00);
      check("rst.addr", imem_addr, 8'h00);
      check("rst.pc", inst_pc, 8'h00);
      check("rst.data", inst_data, 8'h00);
      drive(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
      check("rst.gap", 8'(inst_valid), 8'h00);
      drive(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
      chk_head("rst.restart", 8'h00);

      // PC wrap on the FE-reset instance
      drive(1'b1, 1'b1, 1'b0, 8'h00, 1'b0);
      drive(1'b1, 1'b1, 1'b0, 8'h00, 1'b0);
      for (int c = 0; c < 6; c++) begin
         drive(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
         if (c == 0) check("wrap.addr", imem_addr2, 8'hFE);
         if (c >= 2) begin
            e = 8'hFE + 8'(c - 2);
            check($sformatf("wrap%0d.valid", c), 8'(inst_valid2), 8'h01);
            check($sformatf("wrap%0d.pc", c), inst_pc2, e);
            check($sformatf("wrap%0d.data", c), inst_data2, mem[e]);
         end
      end

      // Random stream: delivered pcs must run sequentially from the last
      // redirect target (or RESET_PC), each with its own memory byte.
      drive(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
      drive(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
      exp_pc = 8'h00; h = 1'b0; prev_hold = 1'b0; prev_pc = 8'h00; prev_dat = 8'h00; pops = 0;
      for (int n = 0; n < 3000; n++) begin
         rv  = ($urandom_range(0, 99) < 4);
         rpc = 8'($urandom);
         if ($urandom_range(0, 99) < 6) h = !h;
         rdy = ($urandom_range(0, 99) < 70);
         drive(1'b0, rdy, rv, rpc, h);
         if (prev_hold) begin
            check("rand.hold.valid", 8'(inst_valid), 8'h01);
            check("rand.hold.pc", inst_pc, prev_pc);
            check("rand.hold.data", inst_data, prev_dat);
         end
         if (inst_valid && inst_ready) begin
            check("rand.pc", inst_pc, exp_pc);
            check("rand.data", inst_data, mem[exp_pc]);
            exp_pc = exp_pc + 8'd1;
            pops++;
         end
         if (rv) begin
            check("rand.addr", imem_addr, rpc);
            exp_pc = rpc;
         end
         prev_hold = inst_valid && !inst_ready && !rv;
         prev_pc   = inst_pc;
         prev_dat  = inst_data;
      end
      check("rand.throughput", 8'(pops >= 200), 8'h01);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
